// File: rtl/zapper_light_sense_if.sv
// zapper_light_sense_if: beam, aim, trigger and result signals of the light-gun sensor
interface zapper_light_sense_if;
  logic       ce_pix;
  logic [5:0] color;
  logic [8:0] count_h;
  logic [8:0] count_v;
  logic [8:0] gun_x;
  logic [8:0] gun_y;
  logic       gun_valid;
  logic       trigger;
  logic       light;
  logic       trigger_out;
  logic [1:0] state_dbg;
  modport master (
    output ce_pix, color, count_h, count_v, gun_x, gun_y, gun_valid, trigger,
    input  light, trigger_out, state_dbg
  );
  modport slave (
    input  ce_pix, color, count_h, count_v, gun_x, gun_y, gun_valid, trigger,
    output light, trigger_out, state_dbg
  );
endinterface

// File: rtl/zapper_light_sense.sv
// zapper_light_sense: Zapper photodiode model on palette indices; ZAPPER_TRIGGER_STRETCH_EN stretches trigger_out over frames
module zapper_light_sense #(
  parameter int RADIUS           = 8,
  parameter int HIT_PIXELS       = 4,
  parameter int HOLD_LINES       = 20,
  parameter int LEVEL_MIN        = 2,
  parameter int TRIG_HOLD_FRAMES = 3
) (
  input logic                 clk,
  input logic                 reset_n,
  zapper_light_sense_if.slave bus
);
  localparam int HW = $clog2(HIT_PIXELS + 1);
  localparam int LW = $clog2(HOLD_LINES + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, LIT = 2'd2} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] hit_q, hit_d, hit_base, hit_inc;
  logic [LW-1:0] hold_q, hold_d;
  logic [1:0] sync_q, sync_d;
  logic signed [9:0] dx, dy;
  logic [9:0] adx, ady;
  logic in_win, bright, new_line;
  assign dx       = $signed({1'b0, bus.count_h}) - $signed({1'b0, bus.gun_x});
  assign dy       = $signed({1'b0, bus.count_v}) - $signed({1'b0, bus.gun_y});
  assign adx      = dx[9] ? 10'(-dx) : 10'(dx);
  assign ady      = dy[9] ? 10'(-dy) : 10'(dy);
  assign in_win   = (bus.count_h <= 9'd255) && (bus.count_v <= 9'd239) &&
                    (adx <= 10'(RADIUS)) && (ady <= 10'(RADIUS));
  assign bright   = (bus.color[5:4] >= 2'(LEVEL_MIN)) && (bus.color[3:0] <= 4'hC);
  assign new_line = bus.ce_pix && (bus.count_h == 9'd0);
  // the line clear happens before a hit on dot 0 is counted
  assign hit_base = new_line ? '0 : hit_q;
  assign hit_inc  = hit_base + 1'b1;
  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    hold_d  = hold_q;
    sync_d  = {sync_q[0], bus.trigger};
    if (bus.ce_pix) begin
      if (!bus.gun_valid) begin
        state_d = IDLE;
        hit_d   = '0;
        hold_d  = '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = SCAN;
            hit_d   = '0;
          end
          SCAN: begin
            hit_d = hit_base;
            if (in_win && bright) begin
              if (hit_inc >= HW'(HIT_PIXELS)) begin
                state_d = LIT;
                hit_d   = HW'(HIT_PIXELS);
                hold_d  = LW'(HOLD_LINES);
              end else begin
                hit_d = hit_inc;
              end
            end
          end
          LIT: begin
            if (new_line) begin
              hold_d = hold_q - 1'b1;
              if (hold_q == LW'(1)) begin
                state_d = SCAN;
                hit_d   = '0;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hit_q   <= '0;
      hold_q  <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      hold_q  <= hold_d;
      sync_q  <= sync_d;
    end
  end
  assign bus.light     = (state_q == LIT);
  assign bus.state_dbg = state_q;
`ifdef ZAPPER_TRIGGER_STRETCH_EN
  localparam int FW = $clog2(TRIG_HOLD_FRAMES + 1);
  logic          prev_q, prev_d, out_q, out_d;
  logic [FW-1:0] frm_q, frm_d;
  always_comb begin
    prev_d = sync_q[1];
    out_d  = out_q;
    frm_d  = frm_q;
    if (!out_q && sync_q[1] && !prev_q) begin
      out_d = 1'b1;
      frm_d = FW'(TRIG_HOLD_FRAMES);
    end else if (out_q && bus.ce_pix && bus.count_v == 9'd0 && bus.count_h == 9'd0) begin
      frm_d = frm_q - 1'b1;
      out_d = (frm_q != FW'(1));
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      out_q  <= 1'b0;
      frm_q  <= '0;
    end else begin
      prev_q <= prev_d;
      out_q  <= out_d;
      frm_q  <= frm_d;
    end
  end
  assign bus.trigger_out = out_q;
`else
  assign bus.trigger_out = sync_q[1];
`endif
endmodule

// File: tb/tb_zapper_light_sense.sv
// tb_zapper_light_sense: directed checks of light sensing, hold, abort, clipping and trigger path
module tb_zapper_light_sense;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  zapper_light_sense_if zif ();
  zapper_light_sense dut (.clk(clk), .reset_n(reset_n), .bus(zif));
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic dot(input int h, input int v, input logic [5:0] c);
    @(negedge clk);
    zif.count_h = 9'(h);
    zif.count_v = 9'(v);
    zif.color   = c;
    zif.ce_pix  = 1'b1;
    @(posedge clk);
    #1 zif.ce_pix = 1'b0;
  endtask
  task automatic span(input int h0, input int h1, input int v, input logic [5:0] c);
    for (int h = h0; h <= h1; h++) dot(h, v, c);
  endtask
  function automatic int nextv(input int v);
    return (v == 239) ? 511 : (v == 511) ? 0 : v + 1;
  endfunction
  task automatic hold_run(input int v0, input string tag);
    int v;
    v = v0;
    for (int i = 1; i <= 20; i++) begin
      v = nextv(v);
      dot(0, v, 6'h0F);
      if (i < 20) begin
        check({tag, "_held"}, zif.light, 1);
        dot(128, v, 6'h30);
      end else begin
        check({tag, "_released"}, zif.light, 0);
        check({tag, "_rel_state"}, zif.state_dbg, 1);
      end
    end
  endtask
  logic [7:0] texp;
  initial begin
`ifdef ZAPPER_TRIGGER_STRETCH_EN
    texp = 8'b1111_1100;
`else
    texp = 8'b0011_1110;
`endif
    zif.ce_pix = 0; zif.color = 0; zif.count_h = 0; zif.count_v = 0;
    zif.gun_x = 128; zif.gun_y = 100; zif.gun_valid = 1; zif.trigger = 1;
    for (int i = 0; i < 3; i++) begin
      dot(128, 100, 6'h30);
      check("rst_light", zif.light, 0);
      check("rst_trig", zif.trigger_out, 0);
      check("rst_state", zif.state_dbg, 0);
    end
    zif.trigger = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1;
    repeat (3) @(posedge clk);
    #1 check("idle_no_ce", zif.state_dbg, 0);
    dot(5, 100, 6'h0F);
    check("idle_to_scan", zif.state_dbg, 1);
    // basic hit at (128,100)
    dot(0, 100, 6'h0F);
    span(124, 126, 100, 6'h30);
    check("basic_3dots", zif.light, 0);
    dot(127, 100, 6'h30);
    check("basic_hit", zif.light, 1);
    check("basic_state", zif.state_dbg, 2);
    hold_run(100, "basic");
    // dark colours and out-of-window
    dot(0, 101, 6'h0F); span(120, 136, 101, 6'h0F); check("dark_0F", zif.light, 0);
    dot(0, 102, 6'h0F); span(120, 136, 102, 6'h1D); check("dark_1D", zif.light, 0);
    dot(0, 103, 6'h0F); span(120, 136, 103, 6'h3E); check("dark_3E", zif.light, 0);
    dot(0, 104, 6'h0F); span(137, 140, 104, 6'h30); check("outside_x", zif.light, 0);
    dot(0, 105, 6'h0F); span(124, 127, 105, 6'h10); check("low_luma", zif.light, 0);
    // window corners, column C at luma 2
    dot(0, 108, 6'h0F);
    dot(120, 108, 6'h2C); dot(136, 108, 6'h2C); dot(121, 108, 6'h2C);
    check("corner_3", zif.light, 0);
    dot(135, 108, 6'h2C);
    check("corner_hit", zif.light, 1);
    zif.gun_valid = 0;
    dot(0, 109, 6'h0F);
    check("abort_light", zif.light, 0);
    check("abort_state", zif.state_dbg, 0);
    // gun_valid drop beats a hit; no advance without ce_pix
    zif.gun_valid = 1;
    dot(1, 100, 6'h0F);
    span(124, 126, 100, 6'h30);
    @(negedge clk); zif.count_h = 127; zif.color = 6'h30;
    repeat (3) @(posedge clk);
    #1 check("no_ce_light", zif.light, 0);
    check("no_ce_state", zif.state_dbg, 1);
    zif.gun_valid = 0;
    dot(127, 100, 6'h30);
    check("valid_beats_hit", zif.light, 0);
    check("valid_beats_state", zif.state_dbg, 0);
    // per-line counter clear
    zif.gun_valid = 1;
    dot(0, 100, 6'h0F);
    span(134, 136, 100, 6'h30);
    dot(0, 101, 6'h0F);
    span(120, 122, 101, 6'h30);
    check("line_clear", zif.light, 0);
    dot(123, 101, 6'h30);
    check("line_4th", zif.light, 1);
    zif.gun_valid = 0; dot(1, 101, 6'h0F);
    // left edge clip at (2,5) and dot-0 hit after clear
    zif.gun_valid = 1; zif.gun_x = 2; zif.gun_y = 5;
    dot(0, 4, 6'h0F);
    span(330, 340, 4, 6'h30);
    check("hblank_dots", zif.light, 0);
    span(1, 3, 4, 6'h30);
    check("edge_line4", zif.light, 0);
    dot(0, 5, 6'h30);
    check("dot0_after_clear", zif.light, 0);
    span(1, 2, 5, 6'h30);
    check("edge_3", zif.light, 0);
    dot(3, 5, 6'h30);
    check("edge_hit", zif.light, 1);
    zif.gun_valid = 0; dot(4, 5, 6'h0F);
    check("edge_abort", zif.state_dbg, 0);
    // hold across frame wrap
    zif.gun_valid = 1; zif.gun_x = 128; zif.gun_y = 236;
    dot(0, 236, 6'h0F);
    span(128, 131, 236, 6'h30);
    check("wrap_hit", zif.light, 1);
    hold_run(236, "wrap");
    zif.gun_valid = 0; dot(1, 0, 6'h0F);
    // trigger path
    @(negedge clk) zif.trigger = 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 check($sformatf("trig_p%0d", k), zif.trigger_out, texp[k]);
      @(negedge clk) if (k == 4) zif.trigger = 0;
    end
    dot(0, 0, 6'h0F);
    check("trig_frame1", zif.trigger_out, texp[7]);
    dot(0, 0, 6'h0F);
    check("trig_frame2", zif.trigger_out, texp[7]);
    @(negedge clk) zif.trigger = 1;
    repeat (5) @(posedge clk);
    @(negedge clk) zif.trigger = 0;
    repeat (4) @(posedge clk);
    #1 check("trig_repress", zif.trigger_out, texp[7]);
    dot(0, 0, 6'h0F);
    check("trig_frame3", zif.trigger_out, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/zapper_light_sense.md
Name: zapper_light_sense

Overview:
- Light-gun (Zapper) photodiode model. It sits alongside the video output stage and consumes the same per-dot palette index and PPU beam counters that feed the palette lookup.
- It decides whether the beam is drawing bright pixels near the gun's aim point, and drives a held "light" flag plus a conditioned trigger to the controller-port logic.
- It works on palette indices, before emphasis, so the result does not depend on the selected palette.

Parameters:
- RADIUS, 8: half-width of the square sensing window, in dots and lines.
- HIT_PIXELS, 4: number of bright dots within one scanline of the window needed to register light.
- HOLD_LINES, 20: scanlines the light flag stays asserted after a hit.
- LEVEL_MIN, 2: minimum luma row (color[5:4]) counted as bright.
- TRIG_HOLD_FRAMES, 3: trigger stretch length, in frames (optional feature only).

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- ce_pix, in, 1: one-cycle dot strobe; all state advances only when it is high.
- color, in, 6: palette index of the current dot.
- count_h, in, 9: PPU dot counter, 0..340.
- count_v, in, 9: PPU line counter; 511 is pre-render, then wraps to 0.
- gun_x, in, 9: aim dot, 0..255.
- gun_y, in, 9: aim line, 0..239.
- gun_valid, in, 1: aim point is on screen.
- trigger, in, 1: raw asynchronous trigger switch.
- light, out, 1: light sensed; active high.
- trigger_out, out, 1: synchronised (optionally stretched) trigger.
- state_dbg, out, 2: current FSM state.

Behaviour:
- Reset (async, reset_n=0): all of the following clear immediately.
  - light=0, trigger_out=0, state=IDLE.
  - hit counter=0, hold counter=0, trigger synchroniser flops=0.
- Bright rule: bright = (color[5:4] >= LEVEL_MIN) && (color[3:0] <= 4'hC).
  - Columns $D-$F are never bright.
- Window rule: in_win = (count_h <= 255) && (count_v <= 239) && |count_h - gun_x| <= RADIUS && |count_v - gun_y| <= RADIUS.
  - Differences are computed signed, 10-bit.
  - The window clips at screen edges; there is no wrap. For example, gun_x=2 covers dots 0..10.
- New-line event: ce_pix && count_h == 0.
- FSM (advances only on ce_pix):
  - IDLE: light=0. Go to SCAN when gun_valid=1.
  - SCAN: on every new-line event the hit counter clears to 0.
    - The counter increments on each dot with in_win && bright, saturating at HIT_PIXELS.
    - When the increment reaches HIT_PIXELS: go to LIT, load hold counter = HOLD_LINES, light=1 on the next clk.
    - Latency is 1 clk after the qualifying ce_pix.
  - LIT: light=1. Each new-line event decrements the hold counter.
    - When it reaches 0: light=0, hit counter=0, go to SCAN.
    - Bright dots in LIT do not retrigger or extend the hold.
    - The hold continues across the frame wrap (count_v 239 -> 511 -> 0).
- gun_valid=0 in any state: next ce_pix goes to IDLE, light=0, counters cleared.
- Simultaneous events, in priority order:
  - gun_valid=0 beats a hit.
  - A hit on dot count_h=0 counts after the line clear, so the hit counter becomes 1, not 0+1 carried.
- state_dbg encoding: IDLE=0, SCAN=1, LIT=2.
- Trigger path: two-flop synchroniser on clk, independent of ce_pix. trigger_out = second flop (default build).

Optional Feature:
- Macro: ZAPPER_TRIGGER_STRETCH_EN.
- When defined:
  - A rising edge of the synchronised trigger sets trigger_out=1 and loads a frame counter = TRIG_HOLD_FRAMES.
  - The counter decrements on each ce_pix where count_v == 0 && count_h == 0.
  - trigger_out clears when the counter reaches 0.
  - Re-presses while held are ignored.
- When undefined: trigger_out = synchronised trigger, 2-clk latency, no counter logic.

Test Plan:
- Reset hold: reset_n=0 with trigger=1, gun_valid=1 → light=0, trigger_out=0, state_dbg=0 throughout; release → state_dbg=1 after first ce_pix.
- Basic hit: gun=(128,100); color=$30 on dots 124..127 of line 100 → light=1 one clk after the ce_pix at dot 127; stays 1 for exactly 20 new-line events, then 0 with state_dbg=1.
- Dark and out-of-window rejection:
  - Color $0F/$1D/$3E across the whole window → light stays 0.
  - Color $30 on dots 137..140 (outside RADIUS) → light stays 0.
  - Color $10 with LEVEL_MIN=2 → light stays 0.
- Per-line reset: 3 bright dots at end of line 100, then 3 at start of line 101 → no hit. A 4th on line 101 → light=1.
- Edge clip and abort:
  - gun=(2,5): bright dots 0..3 on line 5 → hit; no false hits from dots 330..340.
  - Mid-LIT gun_valid=0 → light=0 within one ce_pix, state_dbg=0.
- Trigger: pulse trigger 1 for 5 clks.
  - Default build: trigger_out high for 5 clks, delayed 2.
  - With ZAPPER_TRIGGER_STRETCH_EN: high until the 3rd frame start; a second press during the hold does not extend it.
